// File: rtl/npc_btb_if.sv
// Fetch-side bus of the next-PC unit: the fetch PC and its prediction, plus
// the branch/jump resolution port coming back from execute.
interface npc_btb_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_4;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;

    // res_valid qualifies every res_* field for exactly the cycle it is high.
    // There is no ready: the unit accepts each resolution in that cycle.
    logic             res_valid;
    logic [WIDTH-1:0] res_pc;
    logic [1:0]       res_kind;
    logic             res_taken;
    logic [WIDTH-1:0] res_target;
    logic             res_pred_taken;
    logic [WIDTH-1:0] res_pred_target;
    logic             redirect;

    // master: fetch/execute side that drives stall and resolutions
    modport master (
        output stall, res_valid, res_pc, res_kind, res_taken, res_target,
               res_pred_taken, res_pred_target,
        input  pc, pc_4, pred_taken, pred_target, redirect
    );

    // slave: the next-PC unit itself
    modport slave (
        input  stall, res_valid, res_pc, res_kind, res_taken, res_target,
               res_pred_taken, res_pred_target,
        output pc, pc_4, pred_taken, pred_target, redirect
    );
endinterface

// File: rtl/npc_btb.sv
// Next-PC unit: architectural PC register plus a direct-mapped BTB with
// 2-bit saturating counters, trained by execute and redirecting on mispredict.
module npc_btb #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(32'h0000_3000),
    parameter int               BTB_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    npc_btb_if.slave    bus
);
    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = WIDTH - IDX - 2;

    localparam logic [1:0] KIND_BRANCH   = 2'd0;
    localparam logic [1:0] KIND_RESERVED = 2'd3;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_4;

    logic             btb_valid  [BTB_DEPTH];
    logic [TAG_W-1:0] btb_tag    [BTB_DEPTH];
    logic [WIDTH-1:0] btb_target [BTB_DEPTH];
    logic [1:0]       btb_ctr    [BTB_DEPTH];
    logic             btb_uncond [BTB_DEPTH];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;

    logic [IDX-1:0]   up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             res_active;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;

    // Fetch-side lookup on the registered PC; reads pre-update BTB contents.
    assign pc_4        = pc_q + WIDTH'(4);
    assign lk_idx      = pc_q[IDX+1:2];
    assign lk_tag      = pc_q[WIDTH-1:IDX+2];
    assign lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && (btb_uncond[lk_idx] || btb_ctr[lk_idx][1]);
    assign pred_target = pred_taken ? btb_target[lk_idx] : pc_4;

    assign up_idx      = bus.res_pc[IDX+1:2];
    assign up_tag      = bus.res_pc[WIDTH-1:IDX+2];
    assign up_hit      = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
    assign res_active  = bus.res_valid && (bus.res_kind != KIND_RESERVED);

    assign redirect    = res_active &&
                         ((bus.res_taken != bus.res_pred_taken) ||
                          (bus.res_taken && (bus.res_target != bus.res_pred_target)));
    assign redirect_pc = bus.res_taken ? bus.res_target : bus.res_pc + WIDTH'(4);

    // Redirect outranks stall: a flush must land even while fetch is held.
    always_comb begin
        pc_d = pred_target;
        if (reset) begin
            pc_d = RESET_PC;
        end else if (redirect) begin
            pc_d = redirect_pc;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Training ignores stall; tags and targets need no reset behind valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= 2'b00;
            end
        end else if (res_active) begin
            if (up_hit) begin
                if (bus.res_kind == KIND_BRANCH) begin
                    if (bus.res_taken) begin
                        btb_target[up_idx] <= bus.res_target;
                        if (btb_ctr[up_idx] != 2'b11) begin
                            btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
                        end
                    end else if (btb_ctr[up_idx] != 2'b00) begin
                        btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
                    end
                end else begin
                    btb_target[up_idx] <= bus.res_target;
                    btb_uncond[up_idx] <= 1'b1;
                end
            end else if (bus.res_taken) begin
                btb_valid[up_idx]  <= 1'b1;
                btb_tag[up_idx]    <= up_tag;
                btb_target[up_idx] <= bus.res_target;
                btb_ctr[up_idx]    <= 2'b10;
                btb_uncond[up_idx] <= (bus.res_kind != KIND_BRANCH);
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_4        = pc_4;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;
    assign bus.redirect    = redirect;
endmodule
